// File: rtl/edge_detect_pkg.sv
// Shared edge-select encodings and helpers for the button edge counter.
// Pure definitions; no clocked logic, no latency, no backpressure.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  // Debounce counter width: clog2 of the persistence window, at least one bit.
  function automatic int db_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  function automatic logic edge_sel(input logic [1:0] m, input logic r, input logic f);
    case (mode_e'(m))
      MODE_RISE: return r;
      MODE_FALL: return f;
      MODE_BOTH: return r | f;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One button: synchroniser, debouncer, registered rise/fall pulses.
// Pulses appear SYNC_STAGES+DEBOUNCE_CYC edges after first sample; no backpressure.
module edge_channel
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic rise,
  output logic fall,
  output logic commit_rise,
  output logic commit_fall
);

  localparam int DB_W = db_width(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;
  logic [DB_W-1:0]        db_cnt;
  logic                   commit;

  assign synced      = sync_q[SYNC_STAGES-1];
  assign commit      = (synced != stable) && (db_cnt == DB_LAST);
  // Combinational strobes let the top register pulse alongside rise/fall.
  assign commit_rise = commit & synced;
  assign commit_fall = commit & ~synced;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      stable <= 1'b0;
      db_cnt <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button};
      rise   <= commit_rise;
      fall   <= commit_fall;
      if (synced == stable) begin
        db_cnt <= '0;
      end else if (commit) begin
        stable <= synced;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_edge_counter.sv
// Multi-channel debounced edge detector with mode-selected pulses and wrapping counters.
// Pulse shares the rise/fall cycle, count follows one edge later; no backpressure.
module multi_edge_counter
  import edge_detect_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int CNT_W        = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         buttons,
  input  logic [1:0]              mode,
  input  logic                    clear,
  output logic [N_CH-1:0]         rise,
  output logic [N_CH-1:0]         fall,
  output logic [N_CH-1:0]         pulse,
  output logic [N_CH*CNT_W-1:0]   count,
  output logic                    any_event
);

  logic [N_CH-1:0] commit_rise;
  logic [N_CH-1:0] commit_fall;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .button     (buttons[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .commit_rise(commit_rise[i]),
      .commit_fall(commit_fall[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        pulse[i] <= edge_sel(mode, commit_rise[i], commit_fall[i]);
      end
    end
  end

  // clear wins over a coincident pulse; that event is intentionally dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (pulse[i]) begin
          count[i*CNT_W +: CNT_W] <= count[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  assign any_event = |pulse;

endmodule

// File: tb/tb_multi_edge_counter.sv
// Scoreboarded bench for multi_edge_counter: expected pulses queued at stimulus time.
module tb_multi_edge_counter;
  import edge_detect_pkg::*;

  localparam int N_CH  = 2;
  localparam int CNT_W = 4;
  localparam int DEB   = 4;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + DEB;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       buttons = '0;
  logic [1:0]            mode = MODE_RISE;
  logic                  clear = 1'b0;
  logic [N_CH-1:0]       rise, fall, pulse;
  logic [N_CH*CNT_W-1:0] count;
  logic                  any_event;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] r;
    logic [N_CH-1:0] f;
    logic [N_CH-1:0] p;
  } ev_t;
  ev_t sb[$];

  multi_edge_counter #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(DEB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .buttons  (buttons),
    .mode     (mode),
    .clear    (clear),
    .rise     (rise),
    .fall     (fall),
    .pulse    (pulse),
    .count    (count),
    .any_event(any_event)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the pulses a committed change driven now must produce LAT edges later.
  task automatic push_ev(input int ch, input logic v);
    ev_t  e;
    int   idx = -1;
    logic sel;
    case (mode)
      MODE_RISE: sel = v;
      MODE_FALL: sel = ~v;
      MODE_BOTH: sel = 1'b1;
      default:   sel = 1'b0;
    endcase
    for (int i = 0; i < sb.size(); i++) if (sb[i].cyc == ecnt + LAT) idx = i;
    if (idx < 0) begin
      e.cyc = ecnt + LAT;
      e.r = '0; e.f = '0; e.p = '0;
    end else begin
      e = sb[idx];
    end
    e.r[ch] = v;
    e.f[ch] = ~v;
    e.p[ch] = sel;
    if (idx < 0) sb.push_back(e);
    else sb[idx] = e;
  endtask

  task automatic set_btn(input int ch, input logic v, input bit commits);
    buttons[ch] = v;
    if (commits) push_ev(ch, v);
  endtask

  task automatic press_release(input int ch);
    set_btn(ch, 1'b1, 1'b1);
    tick(LAT + 2);
    set_btn(ch, 1'b0, 1'b1);
    tick(LAT + 2);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (sb.size() > 0 && sb[0].cyc == ecnt) begin
      e = sb.pop_front();
      check("rise", 32'(rise), 32'(e.r));
      check("fall", 32'(fall), 32'(e.f));
      check("pulse", 32'(pulse), 32'(e.p));
      check("any_event", 32'(any_event), 32'(|e.p));
    end else if ((rise | fall | pulse) != '0 || any_event) begin
      check("spurious", 32'({rise, fall, pulse, any_event}), 32'd0);
    end
  end

  initial begin
    tick(1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out", 32'({rise, fall, pulse, any_event}), 32'd0);
    rst = 1'b0;
    tick(2);

    // Clean press and release, rise mode: count moves exactly one edge after pulse
    mode = MODE_RISE;
    set_btn(0, 1'b1, 1'b1);
    tick(LAT);
    check("cnt0_at_pulse", 32'(cnt_of(0)), 32'd0);
    tick(1);
    check("cnt0_after_pulse", 32'(cnt_of(0)), 32'd1);
    tick(2);
    set_btn(0, 1'b0, 1'b1);
    tick(LAT + 2);
    check("cnt0_after_fall", 32'(cnt_of(0)), 32'd1);

    // Bounce shorter than the debounce window is discarded
    set_btn(1, 1'b1, 1'b0);
    tick(3);
    set_btn(1, 1'b0, 1'b0);
    tick(LAT + 4);
    check("bounce_cnt1", 32'(cnt_of(1)), 32'd0);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_cnt", 32'(count), 32'd0);

    // Both edges, 17 pairs -> 34 mod 16
    mode = MODE_BOTH;
    repeat (17) press_release(0);
    check("wrap_cnt0", 32'(cnt_of(0)), 32'd2);

    mode = MODE_NONE;
    repeat (3) press_release(0);
    check("none_cnt0", 32'(cnt_of(0)), 32'd2);

    // Simultaneous commits on both channels each count
    mode = MODE_BOTH;
    set_btn(0, 1'b1, 1'b1);
    set_btn(1, 1'b1, 1'b1);
    tick(LAT + 2);
    check("simul_cnt0", 32'(cnt_of(0)), 32'd3);
    check("simul_cnt1", 32'(cnt_of(1)), 32'd1);
    set_btn(0, 1'b0, 1'b1);
    set_btn(1, 1'b0, 1'b1);
    tick(LAT + 2);
    check("simul_rel_cnt0", 32'(cnt_of(0)), 32'd4);
    check("simul_rel_cnt1", 32'(cnt_of(1)), 32'd2);

    // clear coinciding with pulse[1] wins and the event is lost
    set_btn(1, 1'b1, 1'b1);
    tick(LAT);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_race_cnt1", 32'(cnt_of(1)), 32'd0);
    check("clr_race_cnt0", 32'(cnt_of(0)), 32'd0);
    tick(LAT);
    check("clr_race_late_cnt1", 32'(cnt_of(1)), 32'd0);
    set_btn(1, 1'b0, 1'b1);
    tick(LAT + 2);
    check("post_clr_cnt1", 32'(cnt_of(1)), 32'd1);

    // Reset mid-debounce aborts; button still high gives one rise after release
    mode = MODE_RISE;
    set_btn(0, 1'b1, 1'b0);
    tick(4);
    rst = 1'b1;
    #1;
    check("rst_async_cnt", 32'(count), 32'd0);
    check("rst_async_out", 32'({rise, fall, pulse, any_event}), 32'd0);
    tick(2);
    rst = 1'b0;
    push_ev(0, 1'b1);
    tick(LAT);
    check("rst_rel_cnt0_at_pulse", 32'(cnt_of(0)), 32'd0);
    tick(1);
    check("rst_rel_cnt0", 32'(cnt_of(0)), 32'd1);
    check("rst_rel_cnt1", 32'(cnt_of(1)), 32'd0);
    tick(LAT);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
